// File: rtl/cellrv32_package.sv
// rtl/cellrv32_package.sv - shared address map and register bit positions for the PWM sequencer
package cellrv32_package;

   localparam logic [31:0] pwm_seq_base_c = 32'hFFFFF700;
   localparam int          pwm_seq_size_c = 16;

   localparam logic [31:0] pwm_dc0_addr_c = 32'hFFFFF780;
   localparam logic [31:0] pwm_dc1_addr_c = 32'hFFFFF784;
   localparam logic [31:0] pwm_dc2_addr_c = 32'hFFFFF788;

   localparam logic [1:0] pwm_seq_ctrl_c   = 2'd0;
   localparam logic [1:0] pwm_seq_status_c = 2'd1;
   localparam logic [1:0] pwm_seq_fifo_c   = 2'd2;

   localparam int ctrl_en_c       = 0;
   localparam int ctrl_mask_lsb_c = 1;
   localparam int ctrl_mask_msb_c = 3;
   localparam int ctrl_div_lsb_c  = 8;
   localparam int ctrl_div_msb_c  = 15;
   localparam int ctrl_irq_en_c   = 16;

   localparam int status_empty_c     = 0;
   localparam int status_full_c      = 1;
   localparam int status_underrun_c  = 2;
   localparam int status_overflow_c  = 3;
   localparam int status_level_lsb_c = 8;
   localparam int status_level_msb_c = 15;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   function automatic logic [1:0] lowest_set3(input logic [2:0] v);
      if (v[0]) return 2'd0;
      if (v[1]) return 2'd1;
      return 2'd2;
   endfunction

endpackage

// File: rtl/cellrv32_pwm_seq_fifo.sv
// rtl/cellrv32_pwm_seq_fifo.sv - duty-word FIFO with level output and synchronous flush
module cellrv32_pwm_seq_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [31:0]              wdata_i,
   input  logic                     pop_i,
   output logic [31:0]              rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wptr == rptr);
   assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level_o = wptr - rptr;
   assign rdata_o = mem[rptr[AW-1:0]];

   // a simultaneous pop frees the slot, so a push into a full FIFO is taken then
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem[wptr[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/cellrv32_pwm_seq.sv
// rtl/cellrv32_pwm_seq.sv - streams queued duty words into the PWM dc registers once per divided period
module cellrv32_pwm_seq
   import cellrv32_package::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] addr_i,
   input  logic        rden_i,
   input  logic        wren_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   input  logic        sync_i,
   output logic [31:0] pwm_addr_o,
   output logic [31:0] pwm_data_o,
   output logic        pwm_wren_o,
   input  logic        pwm_ack_i,
   output logic        irq_o
);

   localparam int LO = $clog2(pwm_seq_size_c);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {IDLE, WAIT_SYNC, CHECK, WRITE, WAIT_ACK} state_t;

   state_t      state;
   logic        ctrl_en;
   logic [2:0]  ctrl_mask;
   logic [7:0]  ctrl_div;
   logic        ctrl_irq_en;
   logic        underrun;
   logic        overflow;
   logic [7:0]  div_cnt;
   logic [2:0]  pend;

   logic        sel;
   logic [1:0]  offs;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_flush;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic [LW-1:0] fifo_level;
   logic [7:0]  level8;
   logic [1:0]  frame_len;
   logic [1:0]  cur_idx;
   logic        underrun_set;
   logic        overflow_set;
   logic [31:0] rd_mux;
   logic        unused_addr;

   assign sel         = (addr_i[31:LO] == pwm_seq_base_c[31:LO]);
   assign offs        = addr_i[3:2];
   assign unused_addr = ^addr_i[1:0];
   assign level8      = 8'(fifo_level);
   assign frame_len   = popcount3(ctrl_mask);
   assign cur_idx     = lowest_set3(pend);

   assign fifo_push    = sel & wren_i & (offs == pwm_seq_fifo_c);
   assign fifo_pop     = (state == WAIT_ACK) & pwm_ack_i;
   assign fifo_flush   = (state == IDLE) & ~ctrl_en;
   assign overflow_set = fifo_push & fifo_full & ~fifo_pop;
   assign underrun_set = (state == CHECK) & ctrl_en & (ctrl_mask != 3'b000) &
                         (level8 < {6'd0, frame_len});

   cellrv32_pwm_seq_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .wdata_i (data_i),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      rd_mux = '0;
      case (offs)
         pwm_seq_ctrl_c: begin
            rd_mux[ctrl_en_c]                       = ctrl_en;
            rd_mux[ctrl_mask_msb_c:ctrl_mask_lsb_c] = ctrl_mask;
            rd_mux[ctrl_div_msb_c:ctrl_div_lsb_c]   = ctrl_div;
            rd_mux[ctrl_irq_en_c]                   = ctrl_irq_en;
         end
         pwm_seq_status_c: begin
            rd_mux[status_empty_c]                        = fifo_empty;
            rd_mux[status_full_c]                         = fifo_full;
            rd_mux[status_underrun_c]                     = underrun;
            rd_mux[status_overflow_c]                     = overflow;
            rd_mux[status_level_msb_c:status_level_lsb_c] = level8;
         end
         default: rd_mux = '0;
      endcase
   end

   // host side: registers, sticky flags, bus response and interrupt
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ctrl_en     <= 1'b0;
         ctrl_mask   <= 3'b000;
         ctrl_div    <= 8'd0;
         ctrl_irq_en <= 1'b0;
         underrun    <= 1'b0;
         overflow    <= 1'b0;
         ack_o       <= 1'b0;
         data_o      <= '0;
         irq_o       <= 1'b0;
      end else begin
         ack_o  <= sel & (rden_i | wren_i);
         data_o <= (sel & rden_i) ? rd_mux : '0;
         irq_o  <= ctrl_irq_en & (fifo_empty | underrun);
         if (sel && wren_i && offs == pwm_seq_ctrl_c) begin
            ctrl_en     <= data_i[ctrl_en_c];
            ctrl_mask   <= data_i[ctrl_mask_msb_c:ctrl_mask_lsb_c];
            ctrl_div    <= data_i[ctrl_div_msb_c:ctrl_div_lsb_c];
            ctrl_irq_en <= data_i[ctrl_irq_en_c];
         end
         // a new event wins over a simultaneous write-one-to-clear
         if (underrun_set)
            underrun <= 1'b1;
         else if (sel && wren_i && offs == pwm_seq_status_c && data_i[status_underrun_c])
            underrun <= 1'b0;
         if (overflow_set)
            overflow <= 1'b1;
         else if (sel && wren_i && offs == pwm_seq_status_c && data_i[status_overflow_c])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         div_cnt    <= 8'd0;
         pend       <= 3'b000;
         pwm_wren_o <= 1'b0;
         pwm_addr_o <= '0;
         pwm_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= 8'd0;
               if (ctrl_en && ctrl_mask != 3'b000) state <= WAIT_SYNC;
            end
            WAIT_SYNC: begin
               if (!ctrl_en) begin
                  div_cnt <= 8'd0;
                  state   <= IDLE;
               end else if (sync_i) begin
                  if (div_cnt == ctrl_div) begin
                     div_cnt <= 8'd0;
                     state   <= CHECK;
                  end else begin
                     div_cnt <= div_cnt + 8'd1;
                  end
               end
            end
            CHECK: begin
               if (!ctrl_en || ctrl_mask == 3'b000) begin
                  div_cnt <= 8'd0;
                  state   <= IDLE;
               end else if (!underrun_set) begin
                  pend  <= ctrl_mask;
                  state <= WRITE;
               end else begin
                  state <= WAIT_SYNC;
               end
            end
            WRITE: begin
               if (!ctrl_en) begin
                  div_cnt <= 8'd0;
                  state   <= IDLE;
               end else begin
                  pwm_wren_o <= 1'b1;
                  pwm_data_o <= fifo_head;
                  case (cur_idx)
                     2'd0:    pwm_addr_o <= pwm_dc0_addr_c;
                     2'd1:    pwm_addr_o <= pwm_dc1_addr_c;
                     default: pwm_addr_o <= pwm_dc2_addr_c;
                  endcase
                  pend  <= pend & ~(3'b001 << cur_idx);
                  state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               pwm_wren_o <= 1'b0;
               if (pwm_ack_i) begin
                  if (!ctrl_en) begin
                     div_cnt <= 8'd0;
                     state   <= IDLE;
                  end else if (pend != 3'b000) begin
                     state <= WRITE;
                  end else begin
                     state <= WAIT_SYNC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cellrv32_pwm_seq.sv
// tb/tb_cellrv32_pwm_seq.sv - scoreboard bench for the PWM duty-word sequencer
module tb_cellrv32_pwm_seq;
   import cellrv32_package::*;

   localparam logic [31:0] A_CTRL = pwm_seq_base_c;
   localparam logic [31:0] A_STAT = pwm_seq_base_c + 32'd4;
   localparam logic [31:0] A_FIFO = pwm_seq_base_c + 32'd8;
   localparam logic [31:0] A_RSVD = pwm_seq_base_c + 32'd12;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        rden_i = 1'b0;
   logic        wren_i = 1'b0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        ack_o;
   logic        sync_i = 1'b0;
   logic [31:0] pwm_addr_o;
   logic [31:0] pwm_data_o;
   logic        pwm_wren_o;
   logic        pwm_ack_i = 1'b0;
   logic        irq_o;

   int vec = 0;
   int errs = 0;
   int wr_count = 0;
   int ack_delay = 0;
   logic [63:0] sb [$];

   cellrv32_pwm_seq #(.FIFO_DEPTH(8)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .addr_i     (addr_i),
      .rden_i     (rden_i),
      .wren_i     (wren_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .ack_o      (ack_o),
      .sync_i     (sync_i),
      .pwm_addr_o (pwm_addr_o),
      .pwm_data_o (pwm_data_o),
      .pwm_wren_o (pwm_wren_o),
      .pwm_ack_i  (pwm_ack_i),
      .irq_o      (irq_o)
   );

   always #5 clk_i = ~clk_i;

   // scoreboard consumer: every strobe must match the oldest expected write
   always @(negedge clk_i) begin
      if (rstn_i && pwm_wren_o) begin
         wr_count++;
         vec++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL unexpected_write got addr=%h data=%h, required no write", pwm_addr_o, pwm_data_o);
         end else begin
            logic [63:0] exp;
            exp = sb.pop_front();
            if ({pwm_addr_o, pwm_data_o} !== exp) begin
               errs++;
               $display("FAIL pwm_write got addr=%h data=%h, required addr=%h data=%h",
                        pwm_addr_o, pwm_data_o, exp[63:32], exp[31:0]);
            end
         end
      end
   end

   // PWM-side responder with programmable acknowledge latency
   initial begin
      forever begin
         @(negedge clk_i);
         if (pwm_wren_o) begin
            repeat (ack_delay) @(negedge clk_i);
            pwm_ack_i = 1'b1;
            @(negedge clk_i);
            pwm_ack_i = 1'b0;
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_i);
      addr_i = a;
      data_i = d;
      wren_i = 1'b1;
      @(negedge clk_i);
      wren_i = 1'b0;
      addr_i = '0;
      data_i = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk_i);
      addr_i = a;
      rden_i = 1'b1;
      @(negedge clk_i);
      rden_i = 1'b0;
      addr_i = '0;
      d = data_o;
      vec++;
      if (ack_o !== 1'b1) begin
         errs++;
         $display("FAIL read_ack addr=%h got %b, required 1", a, ack_o);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic [31:0] dc, input bit expect_out);
      if (expect_out) sb.push_back({dc, w});
      bus_write(A_FIFO, w);
   endtask

   task automatic pulse_sync();
      @(negedge clk_i);
      sync_i = 1'b1;
      @(negedge clk_i);
      sync_i = 1'b0;
      repeat (10) @(negedge clk_i);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      vec++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL %s_drain got %0d pending writes, required 0", name, sb.size());
         sb.delete();
      end
      repeat (4) @(negedge clk_i);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      vec++;
      if ({pwm_wren_o, pwm_addr_o, pwm_data_o, irq_o, ack_o, data_o} !== '0) begin
         errs++;
         $display("FAIL reset_outputs got wren=%b addr=%h data=%h irq=%b, required all 0",
                  pwm_wren_o, pwm_addr_o, pwm_data_o, irq_o);
      end
      bus_read(A_CTRL, d);
      vec++;
      if (d !== 32'h0) begin errs++; $display("FAIL reset_ctrl got %h, required 00000000", d); end
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h1) begin errs++; $display("FAIL reset_status got %h, required 00000001", d); end
      bus_read(A_RSVD, d);
      vec++;
      if (d !== 32'h0) begin errs++; $display("FAIL reserved_read got %h, required 00000000", d); end
      @(negedge clk_i);
      addr_i = 32'h0000_1000;
      rden_i = 1'b1;
      @(negedge clk_i);
      rden_i = 1'b0;
      vec++;
      if (ack_o !== 1'b0 || data_o !== 32'h0) begin
         errs++;
         $display("FAIL undecoded_access got ack=%b data=%h, required ack=0 data=0", ack_o, data_o);
      end
   endtask

   task automatic test_full_frame();
      logic [31:0] d;
      bus_write(A_CTRL, 32'h0000_000F);
      push_word(32'h11, pwm_dc0_addr_c, 1);
      push_word(32'h22, pwm_dc1_addr_c, 1);
      push_word(32'h33, pwm_dc2_addr_c, 1);
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h0000_0300) begin errs++; $display("FAIL frame_level_pre got %h, required 00000300", d); end
      pulse_sync();
      wait_drain("full_frame");
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h1) begin errs++; $display("FAIL frame_level_post got %h, required 00000001", d); end
      vec++;
      if (wr_count !== 3) begin errs++; $display("FAIL frame_strobes got %0d, required 3", wr_count); end
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_divider();
      int base;
      bus_write(A_CTRL, 32'h0000_020B);
      push_word(32'hA0, pwm_dc0_addr_c, 1);
      push_word(32'hA1, pwm_dc2_addr_c, 1);
      push_word(32'hA2, pwm_dc0_addr_c, 1);
      push_word(32'hA3, pwm_dc2_addr_c, 1);
      base = wr_count;
      pulse_sync();
      pulse_sync();
      vec++;
      if (wr_count - base !== 0) begin errs++; $display("FAIL div_sync2 got %0d writes, required 0", wr_count - base); end
      pulse_sync();
      vec++;
      if (wr_count - base !== 2) begin errs++; $display("FAIL div_sync3 got %0d writes, required 2", wr_count - base); end
      pulse_sync();
      pulse_sync();
      vec++;
      if (wr_count - base !== 2) begin errs++; $display("FAIL div_sync5 got %0d writes, required 2", wr_count - base); end
      pulse_sync();
      vec++;
      if (wr_count - base !== 4) begin errs++; $display("FAIL div_sync6 got %0d writes, required 4", wr_count - base); end
      wait_drain("divider");
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_underrun();
      logic [31:0] d;
      int base;
      bus_write(A_CTRL, 32'h0001_000F);
      push_word(32'hB0, 32'h0, 0);
      push_word(32'hB1, 32'h0, 0);
      repeat (2) @(negedge clk_i);
      vec++;
      if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_before_underrun got %b, required 0", irq_o); end
      base = wr_count;
      pulse_sync();
      vec++;
      if (wr_count - base !== 0) begin errs++; $display("FAIL underrun_writes got %0d, required 0", wr_count - base); end
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h0000_0204) begin errs++; $display("FAIL underrun_status got %h, required 00000204", d); end
      vec++;
      if (irq_o !== 1'b1) begin errs++; $display("FAIL underrun_irq got %b, required 1", irq_o); end
      bus_write(A_STAT, 32'h4);
      repeat (2) @(negedge clk_i);
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h0000_0200) begin errs++; $display("FAIL underrun_clear got %h, required 00000200", d); end
      vec++;
      if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_after_clear got %b, required 0", irq_o); end
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      int base;
      bus_write(A_CTRL, 32'h0000_0003);
      for (int i = 0; i < 9; i++) push_word(32'hC0 + i, pwm_dc0_addr_c, i < 8);
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h0000_080A) begin errs++; $display("FAIL overflow_status got %h, required 0000080A", d); end
      base = wr_count;
      for (int i = 0; i < 8; i++) pulse_sync();
      wait_drain("overflow");
      vec++;
      if (wr_count - base !== 8) begin errs++; $display("FAIL overflow_writes got %0d, required 8", wr_count - base); end
      bus_write(A_STAT, 32'h8);
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h1) begin errs++; $display("FAIL overflow_clear got %h, required 00000001", d); end
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_en_clear();
      logic [31:0] d;
      int base;
      int n;
      ack_delay = 5;
      bus_write(A_CTRL, 32'h0000_000F);
      push_word(32'hD0, pwm_dc0_addr_c, 1);
      push_word(32'hD1, 32'h0, 0);
      push_word(32'hD2, 32'h0, 0);
      base = wr_count;
      @(negedge clk_i);
      sync_i = 1'b1;
      @(negedge clk_i);
      sync_i = 1'b0;
      n = 0;
      while (!pwm_wren_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      vec++;
      if (!pwm_wren_o) begin errs++; $display("FAIL en_clear_strobe got 0, required 1 within 50 cycles"); end
      bus_write(A_CTRL, 32'h0);
      repeat (20) @(negedge clk_i);
      ack_delay = 0;
      vec++;
      if (wr_count - base !== 1) begin errs++; $display("FAIL en_clear_strobes got %0d, required 1", wr_count - base); end
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h1) begin errs++; $display("FAIL en_clear_status got %h, required 00000001", d); end
      // restart with DIV=1 proves the divider was cleared and the FSM went idle
      bus_write(A_CTRL, 32'h0000_010F);
      push_word(32'hE0, pwm_dc0_addr_c, 1);
      push_word(32'hE1, pwm_dc1_addr_c, 1);
      push_word(32'hE2, pwm_dc2_addr_c, 1);
      base = wr_count;
      pulse_sync();
      vec++;
      if (wr_count - base !== 0) begin errs++; $display("FAIL restart_sync1 got %0d writes, required 0", wr_count - base); end
      pulse_sync();
      wait_drain("restart");
      vec++;
      if (wr_count - base !== 3) begin errs++; $display("FAIL restart_sync2 got %0d writes, required 3", wr_count - base); end
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_reset_wait_ack();
      logic [31:0] d;
      int n;
      ack_delay = 60;
      bus_write(A_CTRL, 32'h0001_000F);
      push_word(32'hF0, pwm_dc0_addr_c, 1);
      push_word(32'hF1, 32'h0, 0);
      push_word(32'hF2, 32'h0, 0);
      @(negedge clk_i);
      sync_i = 1'b1;
      @(negedge clk_i);
      sync_i = 1'b0;
      n = 0;
      while (!pwm_wren_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      repeat (2) @(negedge clk_i);
      #1 rstn_i = 1'b0;
      #1;
      vec++;
      if ({pwm_wren_o, pwm_addr_o, pwm_data_o, irq_o} !== '0) begin
         errs++;
         $display("FAIL async_reset got wren=%b addr=%h data=%h irq=%b, required all 0",
                  pwm_wren_o, pwm_addr_o, pwm_data_o, irq_o);
      end
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      vec++;
      if (ack_o !== 1'b0 || data_o !== 32'h0) begin
         errs++;
         $display("FAIL post_reset_bus got ack=%b data=%h, required 0", ack_o, data_o);
      end
      bus_read(A_STAT, d);
      vec++;
      if (d !== 32'h1) begin errs++; $display("FAIL post_reset_status got %h, required 00000001", d); end
      wait_drain("reset_wait_ack");
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      test_reset();
      test_full_frame();
      test_divider();
      test_underrun();
      test_overflow();
      test_en_clear();
      test_reset_wait_ack();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/cellrv32_pwm_seq.md
CELLRV32_PWM_SEQ -- requirements
Module: cellrv32_pwm_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, duty-word FIFO depth, power of two, 4..64.
REQ-002 SHALL have clk_i  input  1  global clock; duty-word sampling and all state on rising edge.
REQ-003 SHALL have rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have addr_i  input  32  host access address.
REQ-005 SHALL have rden_i / wren_i  input  1 each  host read / write enable.
REQ-006 SHALL have data_i  input  32  host write data.
REQ-007 SHALL have data_o  output  32  host read data.
REQ-008 SHALL have ack_o  output  1  host transfer acknowledge.
REQ-009 SHALL have sync_i  input  1  one-cycle pulse marking a PWM period boundary.
REQ-010 SHALL have pwm_addr_o  output  32  master address towards PWM duty registers.
REQ-011 SHALL have pwm_data_o  output  32  master write data.
REQ-012 SHALL have pwm_wren_o  output  1  master write strobe, one cycle per transfer.
REQ-013 SHALL have pwm_ack_i  input  1  PWM write acknowledge.
REQ-014 SHALL have irq_o  output  1  interrupt request, level.

Function
REQ-015 Decode: access when addr_i[hi:lo] equals pwm_seq_base_c; 16-byte window; word offset addr_i[3:2].
REQ-016 Offset 0 CTRL r/w: bit0 EN, bits3:1 MASK (dc0,dc1,dc2 select), bits15:8 DIV, bit16 IRQ_EN; other bits read 0.
REQ-017 Offset 1 STATUS: bit0 EMPTY, bit1 FULL, bit2 UNDERRUN sticky, bit3 OVERFLOW sticky, bits15:8 fill level; writing 1 to bit2/bit3 clears it.
REQ-018 Offset 2 FIFO push, write-only, reads 0; offset 3 reserved, reads 0, writes ignored.
REQ-019 ack_o SHALL assert exactly one cycle after any decoded rden or wren; data_o SHALL be 0 in every cycle without a registered read.
REQ-020 Push when FULL: word dropped, OVERFLOW set; push and pop in same cycle: level unchanged.
REQ-021 Frame length F = popcount(MASK); frame = F consecutive FIFO words, written to selected dc registers in ascending order (dc0, dc1, dc2).
REQ-022 Divider counts sync_i pulses while EN=1; frame due on every (DIV+1)-th pulse; counter wraps to 0 on due.
REQ-023 FSM states IDLE, WAIT_SYNC, CHECK, WRITE, WAIT_ACK.
REQ-024 IDLE -> WAIT_SYNC when EN=1 and MASK/=0; WAIT_SYNC -> CHECK on due pulse.
REQ-025 CHECK: level >= F -> WRITE with first selected register; else set UNDERRUN, no writes, -> WAIT_SYNC.
REQ-026 WRITE: pwm_wren_o=1 one cycle, pwm_addr_o = pwm_dcN_addr_c, pwm_data_o = FIFO head -> WAIT_ACK.
REQ-027 WAIT_ACK: pwm_addr_o/pwm_data_o held; on pwm_ack_i pop head; next selected register -> WRITE, else -> WAIT_SYNC.
REQ-028 sync_i pulses during CHECK/WRITE/WAIT_ACK SHALL be ignored (not counted).
REQ-029 EN cleared mid-frame: outstanding write completes (waits ack), then IDLE; FIFO flushed, divider cleared, remaining frame words discarded.
REQ-030 EN=0 in IDLE: FIFO flushed and divider held 0 continuously; pushes while EN=0 are accepted and then flushed.
REQ-031 MASK changes take effect at next CHECK only; MASK=0 keeps FSM in IDLE.
REQ-032 irq_o = IRQ_EN and (EMPTY or UNDERRUN), registered, one-cycle latency.

Reset
REQ-033 rstn_i low SHALL asynchronously clear CTRL, sticky flags, FIFO pointers, divider, FSM (IDLE), pwm_wren_o, pwm_addr_o, pwm_data_o, irq_o.
REQ-034 data_o and ack_o SHALL be 0 from the first clock edge after reset release; FIFO storage array needs no reset.

Structure
REQ-035 pwm_seq_base_c, pwm_seq_size_c (16) and the CTRL/STATUS bit-index constants SHALL live in cellrv32_package; pwm_dc0..2_addr_c reused from it.
REQ-036 FSM state type SHALL be a local enum; FIFO SHALL be one sub-module cellrv32_pwm_seq_fifo (depth-parameterised, push/pop/level/full/empty, synchronous flush).

Verification
REQ-037 MASK=3'b111, DIV=0, push 0x11,0x22,0x33, one sync -> writes 0x11@dc0, 0x22@dc1, 0x33@dc2 in order, level 0.
REQ-038 MASK=3'b101, DIV=2, push 4 words -> frames only on sync 3 and 6; dc0 then dc2 each frame.
REQ-039 MASK=3'b111, push 2 words, sync -> no pwm_wren_o, UNDERRUN=1, irq_o=1 if IRQ_EN; write 0x4 to STATUS clears it.
REQ-040 FIFO_DEPTH=8, push 9 words -> FULL=1, OVERFLOW=1, level 8, ninth word never emitted.
REQ-041 Clear EN while pwm_ack_i delayed 5 cycles in first frame write -> strobe not repeated, FSM IDLE after ack, level 0.
REQ-042 Assert rstn_i in WAIT_ACK -> all outputs 0 immediately, STATUS reads 0x00000001 after release.
